// File: rtl/pc_branch_unit.sv
// Program counter with fetch increment, bus load and a three-cycle conditional relative branch.
// Define PC_BRANCH_STATS_EN to add saturating taken/not-taken branch counters.
module pc_branch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               OFFSET_W = 19,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [WIDTH-1:0]    BusMuxOut,
  input  logic                PCin,
  input  logic                IncPC,
  input  logic                br_start,
  input  logic [OFFSET_W-1:0] IR_C,
  input  logic                CON,
  output logic [WIDTH-1:0]    PC,
  output logic                busy,
  output logic                br_done,
  output logic                br_taken
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [15:0]         taken_cnt,
  output logic [15:0]         nottaken_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] off_q, off_ext, pc_nxt;
  logic             con_q, start_ok, commit_taken;

  assign off_ext      = {{(WIDTH-OFFSET_W){IR_C[OFFSET_W-1]}}, IR_C};
  assign busy         = (state != IDLE);
  assign start_ok     = (state == IDLE) && br_start && !PCin;
  // A bus load in COMMIT aborts the branch, so no completion is reported.
  assign br_done      = (state == COMMIT) && !PCin;
  assign commit_taken = br_done && con_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = EVAL;
      EVAL:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (PCin) state_nxt = IDLE;
  end

  always_comb begin
    pc_nxt = PC;
    if (PCin)               pc_nxt = BusMuxOut;
    else if (commit_taken)  pc_nxt = PC + off_q;
    else if (IncPC && !busy) pc_nxt = PC + 1'b1;
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      PC       <= RESET_PC;
      off_q    <= '0;
      con_q    <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      state <= state_nxt;
      PC    <= pc_nxt;
      if (start_ok)        off_q    <= off_ext;
      if (state == EVAL)   con_q    <= CON;
      if (br_done)         br_taken <= con_q;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (br_done) begin
      if (con_q) begin
        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
      end else begin
        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Random and directed stimulus for pc_branch_unit against a cycle-count based reference model.
module tb_pc_branch_unit;
  logic        clk = 1'b0, clear = 1'b1;
  logic [31:0] bus = '0;
  logic        pcin = 1'b0, inc = 1'b0, bs = 1'b0, con = 1'b0;
  logic [18:0] c = '0;
  logic [31:0] pc;
  logic        busy, br_done, br_taken;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] tcnt, ncnt;
`endif

  always #5 clk = ~clk;

  pc_branch_unit dut (
    .clk(clk), .clear(clear), .BusMuxOut(bus), .PCin(pcin), .IncPC(inc),
    .br_start(bs), .IR_C(c), .CON(con), .PC(pc), .busy(busy),
    .br_done(br_done), .br_taken(br_taken)
`ifdef PC_BRANCH_STATS_EN
    , .taken_cnt(tcnt), .nottaken_cnt(ncnt)
`endif
  );

  int nchk = 0, nerr = 0;

  // Model: a branch is remembered by the cycle it started; CON is sampled
  // one cycle later and the result lands two cycles later.
  logic [31:0] m_pc;
  int          m_bstart, m_off, cyc, m_tcnt, m_ncnt;
  logic        m_con, m_taken;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_pc = '0; m_bstart = -1; m_taken = 1'b0; m_con = 1'b0;
    m_tcnt = 0; m_ncnt = 0;
  endfunction

  task automatic step(input logic p, input logic i, input logic b,
                      input logic [18:0] cc, input logic cn, input logic [31:0] d);
    int k;
    pcin = p; inc = i; bs = b; c = cc; con = cn; bus = d;
    k = (m_bstart < 0) ? 0 : cyc - m_bstart;
    @(negedge clk);
    chk("pc", pc, m_pc);
    chk("busy", busy, k != 0);
    chk("br_done", br_done, (k == 2) && !p);
    chk("br_taken", br_taken, m_taken);
`ifdef PC_BRANCH_STATS_EN
    chk("taken_cnt", tcnt, m_tcnt);
    chk("nottaken_cnt", ncnt, m_ncnt);
`endif
    @(posedge clk);
    if (p) begin
      m_pc = d; m_bstart = -1;
    end else if (k == 2) begin
      if (m_con) m_pc = m_pc + m_off;
      m_taken = m_con;
      if (m_con && m_tcnt < 65535) m_tcnt++;
      if (!m_con && m_ncnt < 65535) m_ncnt++;
      m_bstart = -1;
    end else if (k == 1) begin
      m_con = cn;
    end else begin
      if (i) m_pc = m_pc + 1;
      if (b) begin
        m_bstart = cyc;
        m_off = cc[18] ? int'(cc) - 524288 : int'(cc);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 19'd0, 1'b0, 32'd0);
  endtask

  initial begin
    m_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", br_done, 1'b0);
    chk("rst_taken", br_taken, 1'b0);
    clear = 1'b0;

    // clear in the middle of a branch
    step(1'b0, 1'b1, 1'b0, 19'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 19'd7, 1'b0, 32'd0);
    clear = 1'b1;
    #2;
    chk("clr_pc", pc, 32'd0);
    chk("clr_busy", busy, 1'b0);
    m_reset();
    @(posedge clk);
    #1;
    clear = 1'b0;

    repeat (3) step(1'b0, 1'b1, 1'b0, 19'd0, 1'b0, 32'd0);
    chk("inc3", pc, 32'd3);
    step(1'b1, 1'b0, 1'b0, 19'd0, 1'b0, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 19'd0, 1'b0, 32'd0);
    chk("inc_wrap", pc, 32'd0);

    // taken, +5
    step(1'b1, 1'b0, 1'b0, 19'd0, 1'b0, 32'h10);
    step(1'b0, 1'b0, 1'b1, 19'h00005, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 19'd0, 1'b1, 32'd0);
    idle();
    chk("taken_pc", pc, 32'h15);
    chk("taken_flag", br_taken, 1'b1);

    // -4, not taken then taken
    step(1'b1, 1'b0, 1'b0, 19'd0, 1'b0, 32'h20);
    step(1'b0, 1'b0, 1'b1, 19'h7FFFC, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 19'd0, 1'b0, 32'd0);
    idle();
    chk("nt_pc", pc, 32'h20);
    chk("nt_flag", br_taken, 1'b0);
    step(1'b0, 1'b0, 1'b1, 19'h7FFFC, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 19'd0, 1'b1, 32'd0);
    idle();
    chk("neg_pc", pc, 32'h1C);

    // abort during EVAL
    step(1'b0, 1'b0, 1'b1, 19'd5, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 19'd0, 1'b0, 32'h100);
    chk("abort_pc", pc, 32'h100);
    chk("abort_busy", busy, 1'b0);
    idle();
    chk("abort_taken", br_taken, 1'b1);

    // strobes while busy are ignored
    step(1'b0, 1'b0, 1'b1, 19'd3, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 19'd9, 1'b1, 32'd0);
    step(1'b0, 1'b1, 1'b1, 19'd9, 1'b0, 32'd0);
    idle();
    idle();
    chk("ign_pc", pc, 32'h103);

    // inc together with br_start in IDLE
    step(1'b0, 1'b1, 1'b1, 19'h7FFFF, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 19'd0, 1'b1, 32'd0);
    idle();
    chk("inc_br_pc", pc, 32'h103);

    for (int n = 0; n < 2000; n++) begin
      logic        p;
      logic [31:0] d;
      p = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
      step(p, 1'(($urandom >> 3) & 1), ($urandom_range(0, 2) == 0),
           19'($urandom), 1'(($urandom >> 5) & 1), d);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Program-counter stage downstream of the branch-condition flip-flop.
- Holds PC, performs fetch increment and bus loads, and runs a short branch sequence that samples the CON condition bit.
- Commits PC + sign-extended C offset when CON is taken.
- Sits between the datapath bus and the memory address path; driven by the control unit's PCin, IncPC and br_start strobes.

Parameters:
- WIDTH, 32, PC and bus width.
- OFFSET_W, 19, width of the IR constant field C (IR[18:0]); sign-extended to WIDTH.
- RESET_PC, 0, PC value after clear.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- BusMuxOut  in  WIDTH  datapath bus, loaded on PCin.
- PCin  in  1  load PC from BusMuxOut.
- IncPC  in  1  PC <= PC + 1 (word-addressed).
- br_start  in  1  one-cycle pulse; begin branch evaluation.
- IR_C  in  OFFSET_W  branch offset field, valid on the br_start cycle.
- CON  in  1  condition from the con_ff stage.
- PC  out  WIDTH  current program counter.
- busy  out  1  high while the branch FSM is not IDLE.
- br_done  out  1  one-cycle pulse when a branch commits.
- br_taken  out  1  registered result of the last branch; valid from br_done onward.

Behaviour:
- Reset (clear high, asynchronous, any state):
  - PC=RESET_PC, state=IDLE, busy=0, br_done=0, br_taken=0, offset register=0.
- States:
  - IDLE: if br_start, latch sign-extended IR_C into off_q, go EVAL.
  - EVAL: one cycle so con_ff settles on RA, which is on the bus this cycle. Sample CON into con_q at the clock edge, go COMMIT.
  - COMMIT: if con_q=1, PC <= PC + off_q (modulo 2^WIDTH, wrap-around ignored). Otherwise PC is unchanged. br_taken <= con_q, br_done=1 for this cycle only, go IDLE.
- busy = (state != IDLE), combinational from state.
- Latency: br_start at cycle 0, CON sampled at the end of cycle 1, new PC visible in cycle 3.
- Arithmetic:
  - Offset = {(WIDTH-OFFSET_W){IR_C[OFFSET_W-1]}, IR_C}.
  - PC+1 and PC+offset both wrap modulo 2^WIDTH: 0xFFFFFFFF+1=0.
- Priority of PC writes each edge (highest first): clear > PCin > COMMIT-taken > IncPC.
- Simultaneous events:
  - PCin in any non-IDLE state: PC loaded from bus, branch aborted, state -> IDLE, no br_done, br_taken unchanged.
  - IncPC while busy: ignored.
  - IncPC with br_start in IDLE: increment applied and branch starts.
  - br_start while busy: ignored; no queuing.
  - PCin with br_start in IDLE: load wins, br_start ignored.
- CON is ignored outside EVAL.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - At each COMMIT, the matching counter increments, saturating at 0xFFFF.
  - Both counters clear on clear.
  - Aborted branches are not counted.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset/inc: assert clear mid-run -> PC=0, busy=0 immediately. Release, pulse IncPC 3 cycles -> PC=3. Load 0xFFFFFFFF via PCin, IncPC -> PC=0.
- Taken branch: PC=0x10, br_start with IR_C=0x00005, CON=1 in EVAL -> br_done pulse in cycle 2, br_taken=1, PC=0x15 in cycle 3.
- Negative offset, not-taken then taken:
  - PC=0x20, IR_C=0x7FFFC (-4), CON=0 -> PC stays 0x20, br_taken=0.
  - Repeat with CON=1 -> PC=0x1C.
- Abort: br_start, then PCin with bus=0x100 during EVAL -> PC=0x100, state IDLE, no br_done, br_taken keeps its prior value.
- Ignored strobes: IncPC and a second br_start during EVAL/COMMIT -> PC changes only by the branch result; exactly one br_done.
- Stats (PC_BRANCH_STATS_EN): 2 taken + 1 not-taken + 1 aborted -> taken_cnt=2, nottaken_cnt=1. Preload to 0xFFFF and take a branch -> stays 0xFFFF.
